ky32_operand_stage: RTL and testbench

Decode-to-execute operand stage for the KY32 core. It holds the 32×32 general register file and selects the two 32-bit ALU operands from register, immediate or shift-amount sources. It registers the operands together with the 4-bit ALU control code and the destination register in a one-entry pipeline slot. The slot output feeds the KY32 ALU (`a`, `b`, `c`) directly. The writeback port consumes the ALU result one stage later.

---
 rtl/ky32_operand_stage_if.sv | 31 +++
 rtl/ky32_operand_stage.sv | 64 ++++++
 tb/tb_ky32_operand_stage.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ky32_operand_stage_if.sv
// ky32_operand_stage_if: decode-side, writeback and execute-side signals of the KY32 operand stage
interface ky32_operand_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] imm;
  logic [4:0]  shamt;
  logic        asel;
  logic [1:0]  bsel;
  logic [3:0]  alu_c;
  logic [4:0]  dst;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  c;
  logic [4:0]  out_dst;
  modport master (
    output in_valid, rs, rt, imm, shamt, asel, bsel, alu_c, dst, flush, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, a, b, c, out_dst
  );
  modport slave (
    input  in_valid, rs, rt, imm, shamt, asel, bsel, alu_c, dst, flush, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, a, b, c, out_dst
  );
endinterface

// File: rtl/ky32_operand_stage.sv
// ky32_operand_stage: register file and operand select feeding a one-entry ALU pipeline slot
module ky32_operand_stage #(
  parameter bit BYPASS = 1'b1
) (
  input logic clk,
  input logic rst,
  ky32_operand_stage_if.slave io
);
  logic [31:0] r_rf [32];
  logic        r_valid;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [3:0]  r_c;
  logic [4:0]  r_dst;
  logic        w_wr;
  logic        w_ready;
  logic        w_acc;
  logic [31:0] w_rs;
  logic [31:0] w_rt;
  logic [31:0] w_a;
  logic [31:0] w_b;
  always_comb begin
    w_wr = io.wb_en && io.wb_addr != 5'd0;
    w_ready = rst || !r_valid || io.out_ready;
    w_acc = io.in_valid && w_ready && !io.flush;
    w_rs = io.rs == 5'd0 ? 32'd0 : (BYPASS && w_wr && io.wb_addr == io.rs) ? io.wb_data : r_rf[io.rs];
    w_rt = io.rt == 5'd0 ? 32'd0 : (BYPASS && w_wr && io.wb_addr == io.rt) ? io.wb_data : r_rf[io.rt];
    w_a = io.asel ? {27'd0, io.shamt} : w_rs;
    w_b = io.bsel == 2'b01 ? {{16{io.imm[15]}}, io.imm} :
          io.bsel == 2'b10 ? {16'h0000, io.imm} : w_rt;
  end
  always_ff @(posedge clk) begin
    if (rst)
      for (int i = 0; i < 32; i++) r_rf[i] <= 32'd0;
    else if (w_wr)
      r_rf[io.wb_addr] <= io.wb_data;
  end
  // flush outranks accept and consume; a stalled slot keeps its captured operands
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_a <= 32'd0;
      r_b <= 32'd0;
      r_c <= 4'd0;
      r_dst <= 5'd0;
    end else if (io.flush) begin
      r_valid <= 1'b0;
    end else if (w_acc) begin
      r_valid <= 1'b1;
      r_a <= w_a;
      r_b <= w_b;
      r_c <= io.alu_c;
      r_dst <= io.dst;
    end else if (io.out_ready) begin
      r_valid <= 1'b0;
    end
  end
  assign io.in_ready = w_ready;
  assign io.out_valid = r_valid;
  assign io.a = r_a;
  assign io.b = r_b;
  assign io.c = r_c;
  assign io.out_dst = r_dst;
endmodule

// File: tb/tb_ky32_operand_stage.sv
// tb_ky32_operand_stage: directed vectors on bypass and no-bypass builds, scoreboard-checked slot outputs
module tb_ky32_operand_stage;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
    logic [4:0]  d;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] imm;
  logic [4:0]  shamt;
  logic        asel;
  logic [1:0]  bsel;
  logic [3:0]  alu_c;
  logic [4:0]  dst;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_ready;
  int checks = 0;
  int errors = 0;
  exp_t q1[$];
  exp_t q0[$];
  ky32_operand_stage_if f1();
  ky32_operand_stage_if f0();
  assign {f1.in_valid, f1.rs, f1.rt, f1.imm, f1.shamt, f1.asel, f1.bsel, f1.alu_c, f1.dst, f1.flush,
          f1.wb_en, f1.wb_addr, f1.wb_data, f1.out_ready} =
         {in_valid, rs, rt, imm, shamt, asel, bsel, alu_c, dst, flush, wb_en, wb_addr, wb_data, out_ready};
  assign {f0.in_valid, f0.rs, f0.rt, f0.imm, f0.shamt, f0.asel, f0.bsel, f0.alu_c, f0.dst, f0.flush,
          f0.wb_en, f0.wb_addr, f0.wb_data, f0.out_ready} =
         {in_valid, rs, rt, imm, shamt, asel, bsel, alu_c, dst, flush, wb_en, wb_addr, wb_data, out_ready};
  ky32_operand_stage #(.BYPASS(1'b1)) u1 (.clk(clk), .rst(rst), .io(f1.slave));
  ky32_operand_stage #(.BYPASS(1'b0)) u0 (.clk(clk), .rst(rst), .io(f0.slave));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, got, exp);
    end
  endtask
  task automatic op(input logic [4:0] s, input logic [4:0] t, input logic [15:0] im, input logic [4:0] sh,
                    input logic as, input logic [1:0] bs, input logic [3:0] cc, input logic [4:0] d);
    in_valid = 1'b1;
    rs = s;
    rt = t;
    imm = im;
    shamt = sh;
    asel = as;
    bsel = bs;
    alu_c = cc;
    dst = d;
  endtask
  task automatic push(input logic [31:0] a1, input logic [31:0] a0, input logic [31:0] b,
                      input logic [3:0] cc, input logic [4:0] d);
    q1.push_back('{a1, b, cc, d});
    q0.push_back('{a0, b, cc, d});
  endtask
  task automatic wb(input logic en, input logic [4:0] ad, input logic [31:0] da);
    wb_en = en;
    wb_addr = ad;
    wb_data = da;
  endtask
  // a slot cut by flush or reset never completes, so its expectation is discarded
  always @(negedge clk) begin
    exp_t e;
    if (f1.out_valid === 1'b1 && (rst || flush)) begin
      if (q1.size() != 0) void'(q1.pop_front());
    end else if (f1.out_valid === 1'b1 && out_ready) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL mon_bypass1 unexpected output a=%h b=%h c=%h dst=%h", f1.a, f1.b, f1.c, f1.out_dst);
      end else begin
        e = q1.pop_front();
        if ({f1.a, f1.b, f1.c, f1.out_dst} !== e) begin
          errors++;
          $display("FAIL mon_bypass1 got a=%h b=%h c=%h dst=%h expected a=%h b=%h c=%h dst=%h",
                   f1.a, f1.b, f1.c, f1.out_dst, e.a, e.b, e.c, e.d);
        end
      end
    end
    if (f0.out_valid === 1'b1 && (rst || flush)) begin
      if (q0.size() != 0) void'(q0.pop_front());
    end else if (f0.out_valid === 1'b1 && out_ready) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL mon_bypass0 unexpected output a=%h b=%h c=%h dst=%h", f0.a, f0.b, f0.c, f0.out_dst);
      end else begin
        e = q0.pop_front();
        if ({f0.a, f0.b, f0.c, f0.out_dst} !== e) begin
          errors++;
          $display("FAIL mon_bypass0 got a=%h b=%h c=%h dst=%h expected a=%h b=%h c=%h dst=%h",
                   f0.a, f0.b, f0.c, f0.out_dst, e.a, e.b, e.c, e.d);
        end
      end
    end
  end
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    {rs, rt, imm, shamt, asel, bsel, alu_c, dst} = '0;
    flush = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    out_ready = 1'b1;
    step();
    chk("in_ready_in_reset", 32'(f1.in_ready), 32'd1);
    step();
    chk("rst_out_valid", 32'(f1.out_valid), 32'd0);
    chk("rst_a", f1.a, 32'd0);
    chk("rst_b", f1.b, 32'd0);
    chk("rst_c", 32'(f1.c), 32'd0);
    chk("rst_dst", 32'(f1.out_dst), 32'd0);
    rst = 1'b0;
    wb(1'b1, 5'd5, 32'h0000_0010);
    step();
    wb(1'b1, 5'd6, 32'hFFFF_FFF0);
    step();
    wb(1'b0, 5'd0, 32'd0);
    op(5'd5, 5'd6, 16'h0, 5'd0, 1'b0, 2'b00, 4'h4, 5'd7);
    push(32'h10, 32'h10, 32'hFFFF_FFF0, 4'h4, 5'd7);
    step();
    chk("first_out_valid", 32'(f1.out_valid), 32'd1);
    op(5'd5, 5'd6, 16'h8001, 5'd31, 1'b1, 2'b01, 4'h1, 5'd2);
    push(32'h1F, 32'h1F, 32'hFFFF_8001, 4'h1, 5'd2);
    step();
    op(5'd5, 5'd6, 16'h8001, 5'd0, 1'b0, 2'b10, 4'h2, 5'd3);
    push(32'h10, 32'h10, 32'h0000_8001, 4'h2, 5'd3);
    step();
    op(5'd6, 5'd5, 16'h8001, 5'd0, 1'b0, 2'b11, 4'h3, 5'd4);
    push(32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'h10, 4'h3, 5'd4);
    step();
    in_valid = 1'b0;
    wb(1'b1, 5'd0, 32'hDEAD_BEEF);
    step();
    op(5'd0, 5'd0, 16'h0, 5'd0, 1'b0, 2'b00, 4'h5, 5'd1);
    push(32'd0, 32'd0, 32'd0, 4'h5, 5'd1);
    step();
    in_valid = 1'b0;
    wb(1'b1, 5'd9, 32'h1111_1111);
    step();
    op(5'd9, 5'd0, 16'h0, 5'd0, 1'b0, 2'b00, 4'h6, 5'd9);
    wb(1'b1, 5'd9, 32'h1234_5678);
    push(32'h1234_5678, 32'h1111_1111, 32'd0, 4'h6, 5'd9);
    step();
    wb(1'b0, 5'd0, 32'd0);
    op(5'd9, 5'd0, 16'h0, 5'd0, 1'b0, 2'b00, 4'h7, 5'd10);
    push(32'h1234_5678, 32'h1234_5678, 32'd0, 4'h7, 5'd10);
    step();
    op(5'd5, 5'd6, 16'h0, 5'd0, 1'b0, 2'b00, 4'h8, 5'd11);
    push(32'h10, 32'h10, 32'hFFFF_FFF0, 4'h8, 5'd11);
    step();
    out_ready = 1'b0;
    op(5'd6, 5'd5, 16'h0, 5'd0, 1'b0, 2'b00, 4'h9, 5'd12);
    wb(1'b1, 5'd5, 32'h7777_7777);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_in_ready", 32'(f1.in_ready), 32'd0);
      chk("hold_a_bypass1", f1.a, 32'h10);
      chk("hold_a_bypass0", f0.a, 32'h10);
      chk("hold_b", f1.b, 32'hFFFF_FFF0);
      step();
    end
    out_ready = 1'b1;
    wb(1'b0, 5'd0, 32'd0);
    push(32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'h7777_7777, 4'h9, 5'd12);
    step();
    chk("no_gap_valid", 32'(f1.out_valid), 32'd1);
    chk("no_gap_c", 32'(f1.c), 32'h9);
    op(5'd5, 5'd0, 16'h0, 5'd0, 1'b0, 2'b00, 4'hA, 5'd13);
    push(32'h7777_7777, 32'h7777_7777, 32'd0, 4'hA, 5'd13);
    step();
    out_ready = 1'b0;
    flush = 1'b1;
    op(5'd6, 5'd0, 16'h0, 5'd0, 1'b0, 2'b00, 4'hB, 5'd14);
    step();
    chk("flush_out_valid", 32'(f1.out_valid), 32'd0);
    chk("flush_out_valid_b0", 32'(f0.out_valid), 32'd0);
    flush = 1'b0;
    out_ready = 1'b1;
    op(5'd5, 5'd6, 16'h0, 5'd0, 1'b0, 2'b00, 4'hC, 5'd14);
    push(32'h7777_7777, 32'h7777_7777, 32'hFFFF_FFF0, 4'hC, 5'd14);
    step();
    chk("after_flush_c", 32'(f1.c), 32'hC);
    op(5'd6, 5'd0, 16'h0, 5'd0, 1'b0, 2'b00, 4'hD, 5'd15);
    push(32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'd0, 4'hD, 5'd15);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    wb(1'b1, 5'd9, 32'hAAAA_AAAA);
    step();
    rst = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    chk("midrst_out_valid", 32'(f1.out_valid), 32'd0);
    chk("midrst_a", f1.a, 32'd0);
    chk("midrst_b", f1.b, 32'd0);
    chk("midrst_c", 32'(f1.c), 32'd0);
    chk("midrst_dst", 32'(f1.out_dst), 32'd0);
    op(5'd9, 5'd5, 16'h0, 5'd0, 1'b0, 2'b00, 4'hE, 5'd16);
    push(32'd0, 32'd0, 32'd0, 4'hE, 5'd16);
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("scoreboard_drained_b1", 32'(q1.size()), 32'd0);
    chk("scoreboard_drained_b0", 32'(q0.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
